// File: rtl/ads1675_pkg.sv
// Shared types and constants for the ADS1675 capture-path sequencer.
package ads1675_pkg;

  localparam int DW_DEF = 24;
  localparam int TMR_W  = 16;

  typedef enum logic [2:0] {
    OFF,
    PWRUP,
    CONFIG,
    START,
    SETTLE,
    RUN,
    ERROR
  } ctrl_state_t;

  typedef struct packed {
    logic [2:0] dr;
    logic       fpath;
    logic       ll_cfg;
    logic       lvds;
    logic       clk_sel;
  } cfg_pins_t;

endpackage

// File: rtl/ads1675_ctrl_if.sv
// Word stream (valid/data/ready): the receiver-to-controller hop and the controller-to-FIFO hop.
interface ads1675_ctrl_if
  import ads1675_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ads1675_ctrl_timer.sv
// Loadable down-counter that stops at zero; shared by every timed phase of the sequencer.
module ads1675_ctrl_timer #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values no matter how the always_ff blocks are ordered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ads1675_ctrl.sv
// ADS1675 sequencer: power-up, pin configuration, start pulse, settling discard, then
// gated forwarding of receiver words to the FIFO with an inter-word timeout watchdog.
module ads1675_ctrl
  import ads1675_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int PWRUP_CYC   = 1024,
  parameter int CFG_CYC     = 16,
  parameter int START_CYC   = 4,
  parameter int DISCARD     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        reconfig,
  input  logic [2:0]  cfg_dr,
  input  logic        cfg_fpath,
  input  logic        cfg_ll_cfg,
  input  logic        cfg_lvds,
  input  logic        cfg_clk_sel,
  ads1675_ctrl_if.slave  rx,
  ads1675_ctrl_if.master fifo,
  output logic        pown,
  output logic        start,
  output logic        cs_n,
  output logic        dr0,
  output logic        dr1,
  output logic        dr2,
  output logic        fpath,
  output logic        ll_cfg,
  output logic        lvds,
  output logic        clk_sel,
  output logic        running,
  output logic        timeout_err,
  output logic [15:0] drop_cnt
);

  ctrl_state_t      state, state_n;
  cfg_pins_t        pins, cfg_in;
  logic             restart;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             latch_cfg, clr_drop, skip_load, skip_dec, accept, drop;
  logic [7:0]       skip;
  logic             valid_q;
  logic [DW-1:0]    data_q;

  assign cfg_in = '{dr: cfg_dr, fpath: cfg_fpath, ll_cfg: cfg_ll_cfg,
                    lvds: cfg_lvds, clk_sel: cfg_clk_sel};

  // Reconfig only means something once the ADC is powered and past PWRUP, and not in ERROR.
  assign restart = reconfig && (state inside {CONFIG, START, SETTLE, RUN});

  // NOTE: every signal this block drives gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    latch_cfg = 1'b0;
    clr_drop  = 1'b0;
    skip_load = 1'b0;
    skip_dec  = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;

    if (!enable) begin
      state_n = OFF;
    end else if (restart) begin
      state_n   = CONFIG;
      latch_cfg = 1'b1;
      tmr_load  = 1'b1;
      tmr_val   = TMR_W'(CFG_CYC - 1);
    end else begin
      case (state)
        OFF: begin
          state_n  = PWRUP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PWRUP_CYC - 1);
        end
        PWRUP: begin
          if (tmr_zero) begin
            state_n   = CONFIG;
            latch_cfg = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(CFG_CYC - 1);
          end else begin
            tmr_dec = 1'b1;
          end
        end
        CONFIG: begin
          if (tmr_zero) begin
            state_n  = START;
            clr_drop = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(START_CYC - 1);
          end else begin
            tmr_dec = 1'b1;
          end
        end
        START: begin
          if (tmr_zero) begin
            state_n   = SETTLE;
            skip_load = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(TIMEOUT_CYC - 1);
          end else begin
            tmr_dec = 1'b1;
          end
        end
        SETTLE, RUN: begin
          // Watchdog: any received word rearms the full inter-word window.
          if (rx.valid) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
          end else begin
            tmr_dec = 1'b1;
          end

          if (state == SETTLE) begin
            if (skip == '0) begin
              state_n = RUN;
            end else if (rx.valid) begin
              skip_dec = 1'b1;
              if (skip == 8'd1) state_n = RUN;
            end
          end else if (rx.valid) begin
            accept = fifo.ready;
            drop   = !fifo.ready;
          end

          if (!rx.valid && tmr_zero) state_n = ERROR;
        end
        ERROR: ;
        default: state_n = OFF;
      endcase
    end
  end

  ads1675_ctrl_timer #(.W(TMR_W)) u_tmr (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= OFF;
      pown        <= 1'b0;
      cs_n        <= 1'b1;
      start       <= 1'b0;
      running     <= 1'b0;
      timeout_err <= 1'b0;
      pins        <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      drop_cnt    <= '0;
      skip        <= '0;
    end else begin
      state       <= state_n;
      pown        <= (state_n != OFF);
      cs_n        <= (state_n inside {OFF, PWRUP});
      start       <= (state_n == START);
      running     <= (state_n == RUN);
      timeout_err <= (state_n == ERROR);

      if (state_n == OFF) begin
        pins <= '0;
      end else if (latch_cfg) begin
        pins <= cfg_in;
      end

      valid_q <= accept;
      if (accept) data_q <= rx.data;

      if (clr_drop) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      if (skip_load) begin
        skip <= 8'(DISCARD);
      end else if (skip_dec) begin
        skip <= skip - 8'd1;
      end
    end
  end

  assign rx.ready   = 1'b1;
  assign fifo.valid = valid_q;
  assign fifo.data  = data_q;

  assign dr0     = pins.dr[0];
  assign dr1     = pins.dr[1];
  assign dr2     = pins.dr[2];
  assign fpath   = pins.fpath;
  assign ll_cfg  = pins.ll_cfg;
  assign lvds    = pins.lvds;
  assign clk_sel = pins.clk_sel;

endmodule

// File: tb/tb_ads1675_ctrl.sv
// Bench for ads1675_ctrl: a phase/age model of the sequencer checked every cycle, plus
// directed timing, discard, drop, reconfig, timeout and async-reset checks.
module tb_ads1675_ctrl;

  localparam int DW          = 24;
  localparam int PWRUP_CYC   = 1024;
  localparam int CFG_CYC     = 16;
  localparam int START_CYC   = 4;
  localparam int DISCARD     = 2;
  localparam int TIMEOUT_CYC = 4096;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        reconfig = 1'b0;
  logic [2:0]  cfg_dr = 3'b000;
  logic        cfg_fpath = 1'b0, cfg_ll_cfg = 1'b0, cfg_lvds = 1'b0, cfg_clk_sel = 1'b0;
  logic        pown, start, cs_n, dr0, dr1, dr2, fpath, ll_cfg, lvds, clk_sel;
  logic        running, timeout_err;
  logic [15:0] drop_cnt;

  ads1675_ctrl_if #(.DW(DW)) rx ();
  ads1675_ctrl_if #(.DW(DW)) fifo ();

  ads1675_ctrl #(
    .DW(DW), .PWRUP_CYC(PWRUP_CYC), .CFG_CYC(CFG_CYC), .START_CYC(START_CYC),
    .DISCARD(DISCARD), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .reconfig(reconfig),
    .cfg_dr(cfg_dr), .cfg_fpath(cfg_fpath), .cfg_ll_cfg(cfg_ll_cfg),
    .cfg_lvds(cfg_lvds), .cfg_clk_sel(cfg_clk_sel),
    .rx(rx), .fifo(fifo),
    .pown(pown), .start(start), .cs_n(cs_n),
    .dr0(dr0), .dr1(dr1), .dr2(dr2), .fpath(fpath), .ll_cfg(ll_cfg),
    .lvds(lvds), .clk_sel(clk_sel),
    .running(running), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: `up` counts edges since power-up began, `age` counts edges since the last
  // pin latch (CONFIG is age 0..15, START 16..19, streaming from 20), `kept` counts
  // settling words thrown away, `idle` counts word-free edges while streaming.
  int             up = -1, age = -1, kept = 0, idle = 0, e_drop = 0;
  bit             err = 1'b0, e_mv = 1'b0;
  logic [DW-1:0]  e_md = '0;
  logic [6:0]     e_pins = '0;
  localparam int  STREAM_AGE = CFG_CYC + START_CYC;

  function automatic logic [6:0] cfg_now();
    return {cfg_dr, cfg_fpath, cfg_ll_cfg, cfg_lvds, cfg_clk_sel};
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      up = -1; age = -1; kept = 0; idle = 0; err = 1'b0;
      e_mv = 1'b0; e_md = '0; e_drop = 0; e_pins = '0;
    end else begin
      e_mv = 1'b0;
      if (!enable) begin
        up = -1; age = -1; err = 1'b0; e_pins = '0;
      end else if (up < 0) begin
        up = 0;
      end else if (err) begin
        up = up;
      end else if (age < 0) begin
        if (up == PWRUP_CYC - 1) begin
          age = 0; e_pins = cfg_now();
        end else begin
          up++;
        end
      end else if (reconfig) begin
        age = 0; e_pins = cfg_now();
      end else if (age < STREAM_AGE) begin
        age++;
        if (age == CFG_CYC) e_drop = 0;
        kept = 0; idle = 0;
      end else if (rx.valid) begin
        idle = 0;
        if (kept < DISCARD) kept++;
        else if (fifo.ready) begin e_mv = 1'b1; e_md = rx.data; end
        else if (e_drop < 65535) e_drop++;
      end else if (idle == TIMEOUT_CYC - 1) begin
        err = 1'b1;
      end else begin
        idle++;
      end
    end
  end

  always @(negedge aclk) begin
    check("pown", pown, up >= 0);
    check("cs_n", cs_n, age < 0);
    check("start", start, !err && age >= CFG_CYC && age < STREAM_AGE);
    check("running", running, !err && age >= STREAM_AGE && kept == DISCARD);
    check("timeout_err", timeout_err, err);
    check("pins", {dr2, dr1, dr0, fpath, ll_cfg, lvds, clk_sel}, e_pins);
    check("m_valid", fifo.valid, e_mv);
    check("m_data", fifo.data, e_md);
    check("drop_cnt", drop_cnt, e_drop);
  end

  logic [DW-1:0] got[$];
  always @(negedge aclk) if (fifo.valid) got.push_back(fifo.data);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    rx.valid = 1'b1;
    rx.data  = d;
    tick();
    rx.valid = 1'b0;
  endtask

  task automatic pulse_reconfig();
    reconfig = 1'b1;
    tick();
    reconfig = 1'b0;
  endtask

  initial begin
    rx.valid   = 1'b0;
    rx.data    = '0;
    fifo.ready = 1'b1;
    cfg_dr     = 3'b010;
    tick(3);
    aresetn = 1'b1;
    tick(2);

    // Power-up timing: pown one cycle after enable, cs_n at +1025, start for 4 cycles at +1041.
    enable = 1'b1;
    tick();
    check("t1_pown", pown, 1'b1);
    check("t1_cs_n_pwrup", cs_n, 1'b1);
    tick(1023);
    check("t1_cs_n_1024", cs_n, 1'b1);
    tick();
    check("t1_cs_n_1025", cs_n, 1'b0);
    check("t1_dr_latch", {dr2, dr1, dr0}, 3'b010);
    tick(15);
    check("t1_start_1040", start, 1'b0);
    for (int i = 0; i < START_CYC; i++) begin
      tick();
      check("t1_start_high", start, 1'b1);
    end
    tick();
    check("t1_start_low", start, 1'b0);

    // Settling discard: of words 1..5 only 3,4,5 reach the FIFO.
    got.delete();
    for (int w = 1; w <= 5; w++) begin
      send_word(DW'(w));
      tick($urandom_range(0, 2));
    end
    tick(2);
    check("t2_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t2_w0", got[0], 3);
      check("t2_w1", got[1], 4);
      check("t2_w2", got[2], 5);
    end
    check("t2_running", running, 1'b1);

    // Back-pressure: three words lost while the FIFO is full.
    fifo.ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      send_word(DW'($urandom));
      tick(1);
    end
    check("t3_drop_cnt", drop_cnt, 3);
    check("t3_no_push", got.size(), 3);
    fifo.ready = 1'b1;

    // Reconfig in RUN: new pins latched at once, restart clears drop_cnt, two more discarded.
    cfg_dr = 3'b101;
    pulse_reconfig();
    check("t4_dr", {dr2, dr1, dr0}, 3'b101);
    check("t4_drop_kept", drop_cnt, 3);
    cfg_dr = 3'b000;
    tick(CFG_CYC);
    check("t4_start", start, 1'b1);
    check("t4_drop_clr", drop_cnt, 0);
    check("t4_dr_held", {dr2, dr1, dr0}, 3'b101);
    tick(START_CYC);
    got.delete();
    for (int w = 10; w <= 12; w++) begin
      send_word(DW'(w));
      tick(1);
    end
    tick(1);
    check("t4_count", got.size(), 1);
    if (got.size() == 1) check("t4_w", got[0], 12);

    // Random traffic with back-pressure, reconfigs, cfg churn and one power cycle.
    for (int i = 0; i < 3000; i++) begin
      rx.valid   = ($urandom_range(0, 2) == 0);
      rx.data    = DW'($urandom);
      fifo.ready = ($urandom_range(0, 3) != 0);
      reconfig   = ($urandom_range(0, 299) == 0);
      enable     = !(i >= 1000 && i < 1003);
      if ($urandom_range(0, 19) == 0)
        {cfg_dr, cfg_fpath, cfg_ll_cfg, cfg_lvds, cfg_clk_sel} = 7'($urandom);
      tick();
    end
    rx.valid   = 1'b0;
    reconfig   = 1'b0;
    enable     = 1'b1;
    fifo.ready = 1'b1;

    // Watchdog: get back to RUN, then starve the receiver.
    pulse_reconfig();
    tick(STREAM_AGE - 1);
    for (int w = 0; w < 3; w++) send_word(DW'(w + 100));
    check("t5_running", running, 1'b1);
    tick(TIMEOUT_CYC - 1);
    check("t5_no_err_yet", timeout_err, 1'b0);
    tick();
    check("t5_err", timeout_err, 1'b1);
    check("t5_start", start, 1'b0);
    check("t5_running_off", running, 1'b0);
    pulse_reconfig();
    check("t5_err_sticky", timeout_err, 1'b1);
    enable = 1'b0;
    tick();
    check("t5_err_clr", timeout_err, 1'b0);
    check("t5_pown", pown, 1'b0);
    check("t5_cs_n", cs_n, 1'b1);

    // Asynchronous reset while start is high.
    enable = 1'b1;
    tick(PWRUP_CYC + CFG_CYC + 1);
    check("t6_in_start", start, 1'b1);
    #1;
    aresetn = 1'b0;
    #1;
    check("t6_pown", pown, 1'b0);
    check("t6_start", start, 1'b0);
    check("t6_cs_n", cs_n, 1'b1);
    check("t6_pins", {dr2, dr1, dr0, fpath, ll_cfg, lvds, clk_sel}, 7'd0);
    check("t6_running", running, 1'b0);
    check("t6_m_valid", fifo.valid, 1'b0);
    tick(2);
    aresetn = 1'b1;
    tick(5);
    check("t6_repower", pown, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
